memory_bus_responder: RTL and testbench

Target side of the `memory_bus` data interface. It accepts single-cycle `dispatch_read` / `dispatch_write` pulses from `simple_proc`, or any other initiator, and serves them from an internal byte-addressable, little-endian data RAM. It drives `busy` so the initiator waits correctly and returns zero-extended `read_data`; sign extension is the initiator's job. It sits between the CPU core and on-chip data memory, one instance per `memory_bus`.

---
 rtl/memory_bus_responder.sv | 88 ++++++++
 tb/tb_memory_bus_responder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/memory_bus_responder.sv
// memory_bus_responder: memory_bus target serving single-cycle dispatches from a byte-addressable little-endian RAM
module memory_bus_responder #(
  parameter int    DEPTH_WORDS  = 4096,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        dispatch_read,
  input  logic        dispatch_write,
  input  logic [31:0] addr,
  input  logic [1:0]  mem_width,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic [31:0] read_data,
  output logic        err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(READ_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t r_state, w_next;
  logic [AW+1:0] r_addr;
  logic [1:0]    r_width;
  logic [31:0]   r_wdata;
  logic          r_bad;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_read_data;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          w_disp, w_accept, w_bad, w_err, w_done, w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wd, w_word, w_rd;
  assign w_disp   = dispatch_read | dispatch_write;
  assign w_accept = w_disp && r_state == IDLE;
  assign w_bad    = mem_width == 2'd3 || (mem_width == 2'd1 && addr[0]) ||
                    (mem_width == 2'd2 && addr[1:0] != 2'b00) ||
                    {2'b00, addr[31:2]} >= 32'(DEPTH_WORDS);
  assign w_err    = w_disp && (r_state != IDLE || (dispatch_read && dispatch_write) || w_bad);
  assign read_data = r_read_data;
  assign err       = r_err;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE  ? (dispatch_write ? WRITE : dispatch_read ? READ : IDLE) :
             r_state == WRITE ? IDLE :
             w_done           ? IDLE : READ;
  end
  always_comb begin
    busy   = !rst_in && (w_disp || r_state != IDLE);
    w_done = r_state == READ && r_cnt == CW'(READ_LATENCY - 1);
    w_we   = r_state == WRITE && !r_bad && !rst_in;
  end
  // lane steering for the latched request
  always_comb begin
    w_be   = r_width == 2'd0 ? 4'b0001 << r_addr[1:0] :
             r_width == 2'd1 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_wd   = r_width == 2'd0 ? {4{r_wdata[7:0]}} :
             r_width == 2'd1 ? {2{r_wdata[15:0]}} : r_wdata;
    w_word = r_mem[r_addr[AW+1:2]];
    w_rd   = r_width == 2'd0 ? {24'h0, w_word[{r_addr[1:0], 3'b000} +: 8]} :
             r_width == 2'd1 ? {16'h0, w_word[{r_addr[1], 4'b0000} +: 16]} : w_word;
  end
  always_ff @(posedge clk_in)
    if (w_we)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[r_addr[AW+1:2]][8*i +: 8] <= w_wd[8*i +: 8];
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_addr      <= '0;
      r_width     <= '0;
      r_wdata     <= '0;
      r_bad       <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_err <= w_err;
      if (w_accept) begin
        r_addr  <= addr[AW+1:0];
        r_width <= mem_width;
        r_bad   <= w_bad;
        r_cnt   <= '0;
        if (dispatch_write) r_wdata <= write_data;
      end else if (r_state == READ) r_cnt <= r_cnt + 1'b1;
      if (w_done) r_read_data <= r_bad ? 32'h0 : w_rd;
    end
endmodule

// File: tb/tb_memory_bus_responder.sv
// tb_memory_bus_responder: directed checks of memory_bus_responder timing, lanes, errors and reset
module tb_memory_bus_responder;
  logic        clk = 1'b0;
  logic        rst, dr, dw;
  logic [31:0] addr, wd;
  logic [1:0]  w;
  logic        busy, err;
  logic [31:0] rd;
  int n_chk = 0, n_err = 0;
  int bc, ec;
  memory_bus_responder #(.DEPTH_WORDS(64), .READ_LATENCY(2), .INIT_FILE("")) dut (
    .clk_in(clk), .rst_in(rst), .dispatch_read(dr), .dispatch_write(dw),
    .addr(addr), .mem_width(w), .write_data(wd),
    .busy(busy), .read_data(rd), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one access from dispatch until busy drops; bc = busy cycles, ec = err pulses
  task automatic op(input logic r, input logic wr, input logic [31:0] a, input logic [1:0] mw, input logic [31:0] d);
    dr = r; dw = wr; addr = a; w = mw; wd = d;
    #1;
    bc = busy ? 1 : 0;
    ec = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      @(negedge clk);
      dr = 1'b0; dw = 1'b0;
      #1;
      if (err) ec++;
      if (busy) bc++;
    end
  endtask
  initial begin
    rst = 1'b1; dr = 1'b0; dw = 1'b0; addr = '0; w = '0; wd = '0;
    @(negedge clk); @(negedge clk); #1;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_rdata", rd, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    op(0, 1, 32'h10, 2'd2, 32'hDEADBEEF);
    check("wr_busy", bc, 2);
    check("wr_err", ec, 0);
    op(1, 0, 32'h10, 2'd2, 0);
    check("rd_busy", bc, 3);
    check("rd_err", ec, 0);
    check("rd_data", rd, 32'hDEADBEEF);
    op(0, 1, 32'h20, 2'd2, 32'h11223344);
    op(0, 1, 32'h22, 2'd0, 32'h000000AA);
    op(0, 1, 32'h20, 2'd1, 32'h0000BEEF);
    op(1, 0, 32'h20, 2'd2, 0);
    check("lane_dword", rd, 32'h11AABEEF);
    op(1, 0, 32'h23, 2'd0, 0);
    check("lane_byte", rd, 32'h00000011);
    op(1, 0, 32'h22, 2'd1, 0);
    check("lane_word", rd, 32'h000011AA);
    op(0, 1, 32'h21, 2'd1, 32'h00005555);
    check("mis_wr_err", ec, 1);
    check("mis_wr_busy", bc, 2);
    op(1, 0, 32'h22, 2'd2, 0);
    check("mis_rd_err", ec, 1);
    check("mis_rd_busy", bc, 3);
    check("mis_rd_data", rd, 32'h0);
    op(1, 0, 32'h20, 2'd2, 0);
    check("mis_wr_kept", rd, 32'h11AABEEF);
    op(1, 0, 32'h100, 2'd2, 0);
    check("oor_err", ec, 1);
    check("oor_busy", bc, 3);
    check("oor_data", rd, 32'h0);
    op(1, 0, 32'h20, 2'd2, 0);
    op(1, 0, 32'h20, 2'd3, 0);
    check("w3_err", ec, 1);
    check("w3_data", rd, 32'h0);
    dr = 1'b1; addr = 32'h10; w = 2'd2;
    @(negedge clk);
    addr = 32'h20; w = 2'd0;
    #1;
    check("busy_n1_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    dr = 1'b0;
    #1;
    check("busy_disp_err", {31'h0, err}, 32'h1);
    check("busy_n2", {31'h0, busy}, 32'h1);
    @(negedge clk); #1;
    check("busy_n3", {31'h0, busy}, 32'h0);
    check("busy_rd_data", rd, 32'hDEADBEEF);
    check("busy_n3_err", {31'h0, err}, 32'h0);
    op(1, 1, 32'h30, 2'd2, 32'h5);
    check("both_err", ec, 1);
    check("both_busy", bc, 2);
    op(1, 0, 32'h30, 2'd2, 0);
    check("both_data", rd, 32'h5);
    dr = 1'b1; addr = 32'h10; w = 2'd2;
    @(negedge clk);
    dr = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rrst_busy", {31'h0, busy}, 32'h0);
    check("rrst_data", rd, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    op(1, 0, 32'h10, 2'd2, 0);
    check("rrst_after_busy", bc, 3);
    check("rrst_after_data", rd, 32'hDEADBEEF);
    op(0, 1, 32'h40, 2'd2, 32'hCAFEF00D);
    dw = 1'b1; addr = 32'h40; w = 2'd2; wd = 32'h12345678;
    @(negedge clk);
    dw = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("wrst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    op(1, 0, 32'h40, 2'd2, 0);
    check("wrst_kept", rd, 32'hCAFEF00D);
    check("wrst_after_busy", bc, 3);
    op(0, 1, 32'h50, 2'd2, 32'hFFFFFF80);
    op(1, 0, 32'h50, 2'd0, 0);
    check("neg_byte_zext", rd, 32'h00000080);
    op(1, 0, 32'h52, 2'd1, 0);
    check("neg_word_zext", rd, 32'h0000FFFF);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
